// File: rtl/hdmi_clk_sequencer_if.sv
// Control/status bundle between the HDMI clock-tree sequencer and the PLL, CLKDIV, OSER10 and encoder.
// master = sequencer side; slave = clock tree / encoder side.
interface hdmi_clk_sequencer_if;
    logic pll_lock;
    logic calib_req;
    logic clkdiv_resetn;
    logic ser_reset;
    logic pix_resetn;
    logic ready;
    logic calib;
    logic calib_busy;

    modport master (
        input  pll_lock,
        input  calib_req,
        output clkdiv_resetn,
        output ser_reset,
        output pix_resetn,
        output ready,
        output calib,
        output calib_busy
    );

    modport slave (
        output pll_lock,
        output calib_req,
        input  clkdiv_resetn,
        input  ser_reset,
        input  pix_resetn,
        input  ready,
        input  calib,
        input  calib_busy
    );
endinterface

// File: rtl/hdmi_clk_sequencer.sv
// Releases CLKDIV, OSER10 and pixel resets in order after a stable PLL lock; issues CALIB slips in RUN.
// Outputs registered; lock seen 2 edges after pll_lock; no backpressure (calib_req is a level, honoured when idle).
module hdmi_clk_sequencer #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned DIV_SETTLE  = 16,
    parameter int unsigned SER_SETTLE  = 16,
    parameter int unsigned LOSS_FILTER = 4,
    parameter int unsigned CALIB_PULSE = 2,
    parameter int unsigned CALIB_GAP   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    hdmi_clk_sequencer_if.master bus
);

    localparam logic [15:0] LOCK_N  = 16'(LOCK_CYCLES);
    localparam logic [15:0] DIV_N   = 16'(DIV_SETTLE);
    localparam logic [15:0] SER_N   = 16'(SER_SETTLE);
    localparam logic [15:0] LOSS_N  = 16'(LOSS_FILTER);
    localparam logic [15:0] PULSE_N = 16'(CALIB_PULSE);
    localparam logic [15:0] GAP_N   = 16'(CALIB_GAP);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        DIV_SET,
        SER_SET,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, lock_s_q;
    logic [15:0] seq_cnt_q, seq_cnt_d;
    logic [15:0] loss_cnt_q, loss_cnt_d;
    logic [15:0] cal_cnt_q, cal_cnt_d;
    logic        clkdiv_resetn_q, clkdiv_resetn_d;
    logic        ser_reset_q, ser_reset_d;
    logic        pix_resetn_q, pix_resetn_d;
    logic        ready_q, ready_d;
    logic        calib_q, calib_d;
    logic        calib_busy_q, calib_busy_d;
    logic        loss_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q         <= 1'b0;
            lock_s_q        <= 1'b0;
            state_q         <= WAIT_LOCK;
            seq_cnt_q       <= '0;
            loss_cnt_q      <= '0;
            cal_cnt_q       <= '0;
            clkdiv_resetn_q <= 1'b0;
            ser_reset_q     <= 1'b1;
            pix_resetn_q    <= 1'b0;
            ready_q         <= 1'b0;
            calib_q         <= 1'b0;
            calib_busy_q    <= 1'b0;
        end else begin
            sync1_q         <= bus.pll_lock;
            lock_s_q        <= sync1_q;
            state_q         <= state_d;
            seq_cnt_q       <= seq_cnt_d;
            loss_cnt_q      <= loss_cnt_d;
            cal_cnt_q       <= cal_cnt_d;
            clkdiv_resetn_q <= clkdiv_resetn_d;
            ser_reset_q     <= ser_reset_d;
            pix_resetn_q    <= pix_resetn_d;
            ready_q         <= ready_d;
            calib_q         <= calib_d;
            calib_busy_q    <= calib_busy_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        seq_cnt_d       = seq_cnt_q;
        loss_cnt_d      = '0;
        cal_cnt_d       = cal_cnt_q;
        clkdiv_resetn_d = clkdiv_resetn_q;
        ser_reset_d     = ser_reset_q;
        pix_resetn_d    = pix_resetn_q;
        ready_d         = ready_q;
        calib_d         = calib_q;
        calib_busy_d    = calib_busy_q;
        loss_hit        = 1'b0;

        // The filter acts on the registered count, so a loss fires one edge after the count fills.
        if (state_q == DIV_SET || state_q == SER_SET || state_q == RUN) begin
            loss_cnt_d = lock_s_q ? 16'd0 : loss_cnt_q + 16'd1;
            loss_hit   = (loss_cnt_q == LOSS_N);
        end

        case (state_q)
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    if (LOCK_N == 16'd1) begin
                        state_d         = DIV_SET;
                        seq_cnt_d       = '0;
                        clkdiv_resetn_d = 1'b1;
                    end else begin
                        state_d   = STABLE;
                        seq_cnt_d = 16'd1;
                    end
                end
            end
            STABLE: begin
                if (!lock_s_q) begin
                    state_d   = WAIT_LOCK;
                    seq_cnt_d = '0;
                end else if (seq_cnt_q == LOCK_N - 16'd1) begin
                    state_d         = DIV_SET;
                    seq_cnt_d       = '0;
                    clkdiv_resetn_d = 1'b1;
                end else begin
                    seq_cnt_d = seq_cnt_q + 16'd1;
                end
            end
            DIV_SET: begin
                if (seq_cnt_q == DIV_N - 16'd1) begin
                    state_d     = SER_SET;
                    seq_cnt_d   = '0;
                    ser_reset_d = 1'b0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 16'd1;
                end
            end
            SER_SET: begin
                if (seq_cnt_q == SER_N - 16'd1) begin
                    state_d      = RUN;
                    seq_cnt_d    = '0;
                    pix_resetn_d = 1'b1;
                    ready_d      = 1'b1;
                end else begin
                    seq_cnt_d = seq_cnt_q + 16'd1;
                end
            end
            RUN: begin
                // One counter serves both phases: it restarts when calib falls.
                if (!calib_busy_q) begin
                    if (bus.calib_req) begin
                        calib_d      = 1'b1;
                        calib_busy_d = 1'b1;
                        cal_cnt_d    = '0;
                    end
                end else if (calib_q) begin
                    if (cal_cnt_q == PULSE_N - 16'd1) begin
                        calib_d   = 1'b0;
                        cal_cnt_d = '0;
                    end else begin
                        cal_cnt_d = cal_cnt_q + 16'd1;
                    end
                end else begin
                    if (cal_cnt_q == GAP_N - 16'd1) begin
                        calib_busy_d = 1'b0;
                        cal_cnt_d    = '0;
                    end else begin
                        cal_cnt_d = cal_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        if (loss_hit) begin
            state_d         = WAIT_LOCK;
            seq_cnt_d       = '0;
            loss_cnt_d      = '0;
            cal_cnt_d       = '0;
            clkdiv_resetn_d = 1'b0;
            ser_reset_d     = 1'b1;
            pix_resetn_d    = 1'b0;
            ready_d         = 1'b0;
            calib_d         = 1'b0;
            calib_busy_d    = 1'b0;
        end
    end

    assign bus.clkdiv_resetn = clkdiv_resetn_q;
    assign bus.ser_reset     = ser_reset_q;
    assign bus.pix_resetn    = pix_resetn_q;
    assign bus.ready         = ready_q;
    assign bus.calib         = calib_q;
    assign bus.calib_busy    = calib_busy_q;

endmodule
